fault_campaign_ctrl: RTL and testbench

- Synthesizable scheduler for transient fault-injection campaigns on the RISC-V core, used in both FPGA emulation and simulation.
- Sequences periodic injection windows, selects one of NUM_TARGETS target signals (pseudo-random or round-robin) and generates the corruption mask.
- Per-target muxes in the datapath apply the mask (XOR) while fault_active is high.
- Counts injections and stops after a programmed budget.

---
 rtl/fault_campaign_pkg.sv | 12 +
 rtl/fi_lfsr32.sv | 20 ++
 rtl/fault_campaign_ctrl.sv | 117 +++++++++++
 tb/tb_fault_campaign_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_campaign_pkg.sv
// fault_campaign_pkg: shared types and constants for the fault-injection campaign scheduler
// Provides the FSM state type, LFSR polynomial/reset constants, policy encodings and the LFSR step function.
package fault_campaign_pkg;
   typedef enum logic [1:0] {FI_IDLE, FI_WAIT, FI_INJECT, FI_DONE} fi_state_e;
   localparam logic [31:0] LFSR_POLY     = 32'h80200003;
   localparam logic [31:0] LFSR_RESET    = 32'h1;
   localparam logic        FI_POL_RANDOM = 1'b0;
   localparam logic        FI_POL_RR     = 1'b1;
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? (s >> 1) ^ LFSR_POLY : s >> 1;
   endfunction
endpackage

// File: rtl/fi_lfsr32.sv
// fi_lfsr32: 32-bit Galois LFSR (x^32+x^22+x^2+x+1) with seed load and single-step advance
// Ports: clk, rst_n (async, active low); load/seed reload the register, a zero seed maps to LFSR_RESET;
//        step advances one position; next_value is the value the register takes on the next step.
module fi_lfsr32
   import fault_campaign_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        step,
   output logic [31:0] next_value
);
   logic [31:0] lfsr;
   assign next_value = lfsr_step(lfsr);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) lfsr <= LFSR_RESET;
      else if (load) lfsr <= (seed == '0) ? LFSR_RESET : seed;
      else if (step) lfsr <= next_value;
endmodule

// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl: scheduler for periodic transient fault-injection windows
// Inputs:  clk, rst_n (async, active low), enable, policy (0 random / 1 round-robin),
//          mask_mode (0 single bit / 1 random word), seed_load + seed (IDLE only),
//          interval, duration, max_faults (0 = unlimited), pause.
// Outputs: fault_active, fault_sel, fault_onehot, fault_mask, inject_pulse, fault_count, done.
module fault_campaign_ctrl
   import fault_campaign_pkg::*;
#(
   parameter  int NUM_TARGETS = 8,
   parameter  int DATA_W      = 32,
   parameter  int CNT_W       = 16,
   localparam int SEL_W       = $clog2(NUM_TARGETS)
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   policy,
   input  logic                   mask_mode,
   input  logic                   seed_load,
   input  logic [31:0]            seed,
   input  logic [CNT_W-1:0]       interval,
   input  logic [CNT_W-1:0]       duration,
   input  logic [CNT_W-1:0]       max_faults,
   input  logic                   pause,
   output logic                   fault_active,
   output logic [SEL_W-1:0]       fault_sel,
   output logic [NUM_TARGETS-1:0] fault_onehot,
   output logic [DATA_W-1:0]      fault_mask,
   output logic                   inject_pulse,
   output logic [CNT_W-1:0]       fault_count,
   output logic                   done
);
   fi_state_e         state, state_nxt;
   logic [CNT_W-1:0]  wait_cnt, dur_cnt, int_v, dur_v;
   logic [SEL_W-1:0]  rr_ptr, rnd_idx, sel_nxt;
   logic [DATA_W-1:0] rnd_word, mask_nxt;
   logic [31:0]       lfsr_next;
   logic              start, run, inject_go, win_end, budget_hit;

   fi_lfsr32 u_lfsr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (state == FI_IDLE && seed_load),
      .seed       (seed),
      .step       (inject_go),
      .next_value (lfsr_next)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= FI_IDLE;
      else state <= state_nxt;

   always_comb
      state_nxt = !enable   ? FI_IDLE :
                  start     ? FI_WAIT :
                  inject_go ? FI_INJECT :
                  win_end   ? (budget_hit ? FI_DONE : FI_WAIT) : state;

   // strobes and the values latched when a window opens
   always_comb begin
      int_v      = interval == '0 ? CNT_W'(1) : interval;
      dur_v      = duration == '0 ? CNT_W'(1) : duration;
      run        = enable && !pause;
      start      = state == FI_IDLE && enable;
      inject_go  = state == FI_WAIT && run && wait_cnt == CNT_W'(1);
      win_end    = state == FI_INJECT && run && dur_cnt == CNT_W'(1);
      budget_hit = max_faults != '0 && fault_count == max_faults;
      // fold out-of-range indices back for non-power-of-two target counts
      rnd_idx    = {1'b0, lfsr_next[SEL_W-1:0]} >= (SEL_W+1)'(NUM_TARGETS) ?
                   lfsr_next[SEL_W-1:0] - SEL_W'(NUM_TARGETS) : lfsr_next[SEL_W-1:0];
      sel_nxt    = policy == FI_POL_RANDOM ? rnd_idx : rr_ptr;
      rnd_word   = DATA_W'(lfsr_next);
      mask_nxt   = mask_mode ? (rnd_word == '0 ? DATA_W'(1) : rnd_word) :
                   DATA_W'(1) << (lfsr_next[12:8] % DATA_W);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wait_cnt     <= '0;
         dur_cnt      <= '0;
         rr_ptr       <= '0;
         fault_active <= 1'b0;
         fault_sel    <= '0;
         fault_mask   <= '0;
         inject_pulse <= 1'b0;
         fault_count  <= '0;
         done         <= 1'b0;
      end else begin
         inject_pulse <= inject_go;
         if (start) begin
            wait_cnt    <= int_v;
            fault_count <= '0;
            done        <= 1'b0;
            rr_ptr      <= '0;
         end else if (state == FI_WAIT && run) wait_cnt <= wait_cnt - 1'b1;
         if (inject_go) begin
            dur_cnt      <= dur_v;
            fault_active <= 1'b1;
            fault_sel    <= sel_nxt;
            fault_mask   <= mask_nxt;
            fault_count  <= &fault_count ? fault_count : fault_count + 1'b1;
            if (policy == FI_POL_RR) rr_ptr <= rr_ptr == SEL_W'(NUM_TARGETS - 1) ? '0 : rr_ptr + 1'b1;
         end else if (state == FI_INJECT && run) dur_cnt <= dur_cnt - 1'b1;
         if (win_end) begin
            fault_active <= 1'b0;
            fault_mask   <= '0;
            wait_cnt     <= int_v;
            done         <= budget_hit;
         end
         if (!enable) begin
            fault_active <= 1'b0;
            fault_mask   <= '0;
         end
      end

   assign fault_onehot = fault_active ? (NUM_TARGETS'(1) << fault_sel) : '0;
endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// tb_fault_campaign_ctrl: randomized self-checking bench against a window-timeline reference model
module tb_fault_campaign_ctrl;
   localparam int NT = 8;
   localparam int DW = 32;
   localparam int CW = 16;
   logic          clk = 1'b0;
   logic          rst_n, enable, policy, mask_mode, seed_load, pause;
   logic [31:0]   seed;
   logic [CW-1:0] interval, duration, max_faults;
   logic          fault_active, inject_pulse, done;
   logic [2:0]    fault_sel;
   logic [NT-1:0] fault_onehot;
   logic [DW-1:0] fault_mask;
   logic [CW-1:0] fault_count;
   int            n_checks = 0;
   int            n_fail = 0;

   fault_campaign_ctrl #(.NUM_TARGETS(NT), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .policy       (policy),
      .mask_mode    (mask_mode),
      .seed_load    (seed_load),
      .seed         (seed),
      .interval     (interval),
      .duration     (duration),
      .max_faults   (max_faults),
      .pause        (pause),
      .fault_active (fault_active),
      .fault_sel    (fault_sel),
      .fault_onehot (fault_onehot),
      .fault_mask   (fault_mask),
      .inject_pulse (inject_pulse),
      .fault_count  (fault_count),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] m_adv(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
   endfunction

   function automatic int m_idx(input logic [31:0] v);
      int i;
      i = int'(v[2:0]);
      return i >= NT ? i - NT : i;
   endfunction

   // Window k opens at effective time iv + k*(iv+dv) and lasts dv cycles; effective time only
   // advances on unpaused edges, and a paused edge shows no strobe.
   task automatic run_campaign(input string tag, input int iv_in, input int dv_in, input int nf,
                               input logic pol, input logic mm, input logic [31:0] sd,
                               input int pause_pct, input bit junk_seed, input int len);
      int            iv, dv, per, e, k, r, started;
      bit            act, pul, dn, pe;
      logic [31:0]   lf;
      logic [NT-1:0] oh;
      int            esel[64];
      logic [31:0]   emask[64];
      iv  = iv_in == 0 ? 1 : iv_in;
      dv  = dv_in == 0 ? 1 : dv_in;
      per = iv + dv;
      lf  = sd == 0 ? 32'h1 : sd;
      for (int i = 0; i < 64; i++) begin
         lf       = m_adv(lf);
         esel[i]  = pol ? i % NT : m_idx(lf);
         emask[i] = mm ? (lf == 0 ? 32'h1 : lf) : 32'h1 << lf[12:8];
      end
      enable = 0; pause = 0; seed_load = 0;
      tick; tick;
      seed = sd; seed_load = 1;
      tick;
      seed_load = 0;
      interval = CW'(iv_in); duration = CW'(dv_in); max_faults = CW'(nf);
      policy = pol; mask_mode = mm; enable = 1;
      e = 0;
      for (int n = 0; n < len; n++) begin
         pe = pause;
         tick;
         if (n > 0 && !pe) e++;
         act = 0; pul = 0; k = 0; started = 0;
         if (e >= iv) begin
            k       = (e - iv) / per;
            r       = (e - iv) % per;
            started = k + 1;
            act     = r < dv && (nf == 0 || k < nf);
            pul     = act && r == 0 && !pe;
         end
         if (nf != 0 && started > nf) started = nf;
         dn = nf != 0 && e >= iv + (nf - 1) * per + dv;
         n_checks++;
         if (fault_active !== act) begin n_fail++; $display("FAIL %s active n=%0d got %b want %b", tag, n, fault_active, act); end
         n_checks++;
         if (inject_pulse !== pul) begin n_fail++; $display("FAIL %s pulse n=%0d got %b want %b", tag, n, inject_pulse, pul); end
         n_checks++;
         if (done !== dn) begin n_fail++; $display("FAIL %s done n=%0d got %b want %b", tag, n, done, dn); end
         n_checks++;
         if (fault_count !== CW'(started)) begin n_fail++; $display("FAIL %s count n=%0d got %0d want %0d", tag, n, fault_count, started); end
         if (act) begin
            oh = NT'(1) << esel[k];
            n_checks++;
            if (fault_sel !== 3'(esel[k])) begin n_fail++; $display("FAIL %s sel n=%0d got %0d want %0d", tag, n, fault_sel, esel[k]); end
            n_checks++;
            if (fault_mask !== emask[k]) begin n_fail++; $display("FAIL %s mask n=%0d got %h want %h", tag, n, fault_mask, emask[k]); end
            n_checks++;
            if (fault_onehot !== oh) begin n_fail++; $display("FAIL %s onehot n=%0d got %b want %b", tag, n, fault_onehot, oh); end
         end else begin
            n_checks++;
            if (fault_mask !== '0) begin n_fail++; $display("FAIL %s idle_mask n=%0d got %h want 0", tag, n, fault_mask); end
            n_checks++;
            if (fault_onehot !== '0) begin n_fail++; $display("FAIL %s idle_onehot n=%0d got %b want 0", tag, n, fault_onehot); end
         end
         pause = (n + 1 < len) && ($urandom_range(99) < pause_pct);
         if (junk_seed) begin seed_load = 1; seed = $urandom; end
      end
      pause = 0; seed_load = 0;
   endtask

   task automatic test_reset;
      rst_n = 0;
      enable = 1'($urandom_range(1)); policy = 1'($urandom_range(1)); mask_mode = 1'($urandom_range(1));
      seed_load = 1'($urandom_range(1)); seed = $urandom; pause = 0;
      interval = CW'($urandom_range(5)); duration = CW'($urandom_range(5)); max_faults = CW'($urandom_range(5));
      tick; tick;
      n_checks++;
      if ({fault_active, inject_pulse, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {fault_active, inject_pulse, done}); end
      n_checks++;
      if (fault_sel !== '0 || fault_onehot !== '0) begin n_fail++; $display("FAIL reset_sel got %0d/%b want 0/0", fault_sel, fault_onehot); end
      n_checks++;
      if (fault_mask !== '0 || fault_count !== '0) begin n_fail++; $display("FAIL reset_mask_count got %h/%0d want 0/0", fault_mask, fault_count); end
      enable = 0; seed_load = 0;
      #3 rst_n = 1;
   endtask

   task automatic test_reset_lfsr;
      bit hit = 0;
      enable = 0; tick; tick;
      policy = 0; mask_mode = 1; interval = 1; duration = 1; max_faults = 1; enable = 1;
      for (int i = 0; i < 10 && !hit; i++) begin tick; hit = inject_pulse; end
      n_checks++;
      if (!hit) begin n_fail++; $display("FAIL lfsr_reset_pulse got none want pulse"); end
      n_checks++;
      if (fault_mask !== 32'h80200003) begin n_fail++; $display("FAIL lfsr_reset_mask got %h want 80200003", fault_mask); end
      n_checks++;
      if (fault_sel !== 3'd3) begin n_fail++; $display("FAIL lfsr_reset_sel got %0d want 3", fault_sel); end
   endtask

   task automatic test_pause;
      int pulses = 0, act_n = 0, pulse_n = -1;
      enable = 0; pause = 0; tick; tick;
      policy = 1; interval = 4; duration = 3; max_faults = 1; enable = 1;
      for (int n = 0; n < 25; n++) begin
         tick;
         if (inject_pulse) begin pulses++; pulse_n = n; end
         if (fault_active) act_n++;
         pause = (n >= 1 && n <= 5) || (n >= 10 && n <= 14);
      end
      pause = 0;
      n_checks++;
      if (pulse_n !== 9) begin n_fail++; $display("FAIL pause_wait_stretch got %0d want 9", pulse_n); end
      n_checks++;
      if (pulses !== 1) begin n_fail++; $display("FAIL pause_pulses got %0d want 1", pulses); end
      n_checks++;
      if (act_n !== 8) begin n_fail++; $display("FAIL pause_active_stretch got %0d want 8", act_n); end
      n_checks++;
      if (done !== 1'b1 || fault_count !== 1) begin n_fail++; $display("FAIL pause_done got %b/%0d want 1/1", done, fault_count); end
   endtask

   task automatic test_enable_drop;
      int pulses = 0;
      enable = 0; tick; tick;
      policy = 1; interval = 2; duration = 3; max_faults = 0; enable = 1;
      for (int i = 0; i < 40 && pulses < 2; i++) begin tick; if (inject_pulse) pulses++; end
      n_checks++;
      if (pulses !== 2) begin n_fail++; $display("FAIL drop_wait got %0d pulses want 2", pulses); end
      n_checks++;
      if (fault_sel !== 3'd1) begin n_fail++; $display("FAIL drop_sel got %0d want 1", fault_sel); end
      enable = 0;
      tick;
      n_checks++;
      if (fault_active !== 1'b0 || fault_mask !== '0 || fault_onehot !== '0) begin n_fail++; $display("FAIL drop_clear got %b/%h/%b want 0/0/0", fault_active, fault_mask, fault_onehot); end
      tick;
      n_checks++;
      if (fault_count !== 2) begin n_fail++; $display("FAIL drop_count_held got %0d want 2", fault_count); end
      enable = 1;
      tick;
      n_checks++;
      if (fault_count !== 0) begin n_fail++; $display("FAIL reenable_count got %0d want 0", fault_count); end
      pulses = 0;
      for (int i = 0; i < 10 && pulses == 0; i++) begin tick; if (inject_pulse) pulses++; end
      n_checks++;
      if (pulses !== 1 || fault_sel !== 3'd0 || fault_count !== 1) begin n_fail++; $display("FAIL reenable_rr got pulse=%0d sel=%0d count=%0d want 1/0/1", pulses, fault_sel, fault_count); end
   endtask

   task automatic test_random;
      int iv, dv, nf, len;
      logic [31:0] sd;
      for (int c = 0; c < 8; c++) begin
         iv  = $urandom_range(5);
         dv  = $urandom_range(4);
         nf  = $urandom_range(4);
         len = nf != 0 ? ((iv == 0 ? 1 : iv) + (dv == 0 ? 1 : dv)) * nf + 15 : 50;
         sd  = $urandom_range(3) == 0 ? 32'h0 : $urandom;
         run_campaign("rand", iv, dv, nf, 1'($urandom_range(1)), 1'($urandom_range(1)), sd,
                      int'($urandom_range(1)) * 25, 1'($urandom_range(1)), len);
      end
   endtask

   task automatic test_async_reset;
      enable = 0; tick; tick;
      policy = 1; interval = 2; duration = 5; max_faults = 0; enable = 1;
      for (int i = 0; i < 20 && !fault_active; i++) tick;
      n_checks++;
      if (fault_active !== 1'b1) begin n_fail++; $display("FAIL areset_wait got %b want 1", fault_active); end
      @(negedge clk);
      rst_n = 0;
      #1;
      n_checks++;
      if (fault_active !== 1'b0 || fault_mask !== '0 || fault_onehot !== '0) begin n_fail++; $display("FAIL areset_immediate got %b/%h/%b want 0/0/0", fault_active, fault_mask, fault_onehot); end
      n_checks++;
      if (fault_count !== '0 || done !== 1'b0 || inject_pulse !== 1'b0) begin n_fail++; $display("FAIL areset_state got %0d/%b/%b want 0/0/0", fault_count, done, inject_pulse); end
      enable = 0;
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      test_reset;
      test_reset_lfsr;
      run_campaign("example", 4, 2, 3, 1'b1, 1'b0, 32'h1234_5678, 0, 1'b0, 21);
      run_campaign("seed_zero", 3, 2, 2, 1'b0, 1'b1, 32'h0, 0, 1'b0, 20);
      run_campaign("rr_wrap", 1, 1, 0, 1'b1, 1'b0, 32'hdead_beef, 0, 1'b0, 24);
      test_pause;
      test_enable_drop;
      run_campaign("zero_cfg", 0, 0, 4, 1'b0, 1'b0, 32'hace1_0001, 0, 1'b1, 14);
      test_random;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
